mctrl_fsm: RTL
==============

Name: mctrl_fsm

Overview:
- Multicycle MIPS control unit, directly upstream of the multicycle datapath.
- Drives every datapath mux select, register/PC/IR write enable and ALU op from a 16-state Moore FSM.
- Decodes the latched instruction word (IR output) and consumes zero/overflow/MIO_ready back from the datapath and memory bus.
- Also drives memory request strobes to the MIO bus.

Parameters:
- RESET_STATE, 4'd0, state entered on reset (IF); keep 0.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-low reset
- Inst  in  32  IR contents (stable from end of IF until next IF)
- zero  in  1  ALU zero flag
- overflow  in  1  ALU signed overflow flag
- MIO_ready  in  1  memory transaction complete this cycle
- MemRead  out  1  memory read request
- MemWrite  out  1  memory write request
- IorD  out  1  0=PC, 1=ALUOut drives M_addr
- IRWrite  out  1  IR load enable
- RegDst  out  2  0=rt, 1=rd, 2=$31
- RegWrite  out  1  register file write enable
- MemtoReg  out  2  0=ALUOut, 1=MDR, 2=lui, 3=PC
- ALUSrcA  out  1  0=PC, 1=rs
- ALUSrcB  out  2  0=rt, 1=4, 2=imm, 3=imm<<2
- PCSource  out  2  0=ALU result, 1=ALUOut, 2=jump target, 3=rs
- PCWrite  out  1  unconditional PC write
- PCWriteCond  out  1  conditional PC write
- Branch  out  1  1=beq (taken on zero), 0=bne
- ALU_operation  out  3  000 AND, 001 OR, 010 ADD, 011 XOR, 100 NOR, 101 SRL, 110 SUB, 111 SLT
- shift  out  1  1 selects immediate/shamt as ALU A (srl)
- unsign  out  1  1 selects zero-extended immediate
- state_out  out  4  current state, for debug display

Behaviour:
- State register updates on the rising clk edge. reset==0 at an edge sets state=IF and ov_q=0. While reset==0, all outputs are forced to 0.
- All outputs are combinational from state and Inst. Anything not listed below is 0.

States, outputs and transitions:
- IF(0): MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=1, ADD, PCSource=0, PCWrite=1, IRWrite=MIO_ready.
  - Stay in IF while MIO_ready=0; go to ID when MIO_ready=1.
  - The PC is gated by MIO_ready in the datapath.
- ID(1): ALUSrcA=0, ALUSrcB=3, ADD (ALUOut=PC+4+offset). Next state by opcode:
  - lw/sw -> MA
  - R-type (000000) -> RE, except funct 001000 -> JR
  - beq 000100 / bne 000101 -> BR
  - j 000010 -> J
  - jal 000011 -> JAL
  - addi 001000, slti 001010, andi 001100, ori 001101, xori 001110 -> IE
  - lui 001111 -> LUI
  - anything else -> ERR
- MA(2): ALUSrcA=1, ALUSrcB=2, ADD. lw -> MR, sw -> MW.
- MR(3): MemRead=1, IorD=1. Wait for MIO_ready, then -> LW.
- LW(4): RegDst=0, MemtoReg=1, RegWrite=1. -> IF.
- MW(5): MemWrite=1, IorD=1. Wait for MIO_ready, then -> IF.
- RE(6): ALUSrcA=1, ALUSrcB=0, ALU op by funct:
  - add 100000 -> ADD; sub 100010 -> SUB; and 100100 -> AND; or 100101 -> OR
  - xor 100110 -> XOR; nor 100111 -> NOR; slt 101010 -> SLT
  - srl 000010 -> SRL with shift=1
  - unknown funct -> ERR
  - Latch ov_q=overflow for add/sub, else 0. -> RW.
- RW(7): RegDst=1, MemtoReg=0, RegWrite=~ov_q. -> IF.
- BR(8): ALUSrcA=1, ALUSrcB=0, SUB, PCWriteCond=1, PCSource=1, Branch=(opcode==beq). -> IF.
- J(9): PCSource=2, PCWrite=1. -> IF.
- IE(10): ALUSrcA=1, ALUSrcB=2, op ADD/SLT/AND/OR/XOR. unsign=1 for andi/ori/xori. Latch ov_q=overflow for addi only. -> IW.
- IW(11): RegDst=0, MemtoReg=0, RegWrite=~ov_q. -> IF.
- LUI(12): RegDst=0, MemtoReg=2, RegWrite=1. -> IF.
- JAL(13): RegDst=2, MemtoReg=3, RegWrite=1, PCSource=2, PCWrite=1, all in the same cycle.
  - The register file captures the pre-edge PC, which is already PC+4.
  - -> IF.
- JR(14): PCSource=3, PCWrite=1. -> IF.
- ERR(15): all outputs 0. Stuck until reset.

Cycle counts with zero memory wait:
- lw 5; R-type, I-type and sw 4; beq/bne, j, jal, jr and lui 3.
- Each cycle of MIO_ready=0 in IF/MR/MW adds exactly one cycle.

Boundary conditions:
- Reset asserted mid-transaction (including during a wait in MR/MW): next state is IF.
- The pending memory strobe drops in the same cycle reset goes low.
- ov_q holds between EXE and WB; it is cleared on reset and on entry to IF.

Decomposition:
- Package mctrl_pkg holds:
  - state encodings S_IF..S_ERR
  - opcode and funct constants
  - ALU_operation constants
  - mux-select constants (SRCB_4, PCSRC_JUMP, etc.)
- One sub-module, mctrl_decode: combinational map from Inst[31:26] and Inst[5:0] to instruction class, ALU op, unsign and shift. It is reused by the FSM's next-state and output logic.

Test Plan:
- add $3,$1,$2 (0x00221820), MIO_ready=1 -> state sequence 0,1,6,7,0; in cycle 4 RegWrite=1, RegDst=1, MemtoReg=0.
- lw $5,8($0) (0x8C050008), MIO_ready low for 2 cycles in MR -> sequence 0,1,2,3,3,3,4,0; MemRead=1 and IorD=1 throughout MR; RegWrite=1 with MemtoReg=1 in state 4.
- beq 0x10220003 with zero=1 in BR -> PCWriteCond=1, Branch=1, PCSource=1; bne 0x14220003 in BR -> Branch=0.
- jal 0x0C000010 -> state 13 with PCWrite=1, RegWrite=1, RegDst=2, MemtoReg=3 simultaneously; back to IF next cycle.
- addi with overflow=1 in IE -> RegWrite=0 in IW; ori 0x3421FFFF -> unsign=1, ALU_operation=001.
- Opcode 0x3F -> ERR with all outputs 0; reset=0 for one edge -> state_out=0 and MemRead=1 once reset returns high.

Source files
------------

// File: rtl/mctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: states, opcodes,
// function codes, ALU operations and datapath mux selects.
package mctrl_pkg;

  typedef enum logic [3:0] {
    S_IF  = 4'd0,
    S_ID  = 4'd1,
    S_MA  = 4'd2,
    S_MR  = 4'd3,
    S_LW  = 4'd4,
    S_MW  = 4'd5,
    S_RE  = 4'd6,
    S_RW  = 4'd7,
    S_BR  = 4'd8,
    S_J   = 4'd9,
    S_IE  = 4'd10,
    S_IW  = 4'd11,
    S_LUI = 4'd12,
    S_JAL = 4'd13,
    S_JR  = 4'd14,
    S_ERR = 4'd15
  } state_t;

  typedef enum logic [3:0] {
    CL_MEM, CL_R, CL_JR, CL_BR, CL_J, CL_JAL, CL_IMM, CL_LUI, CL_BAD
  } inst_cls_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_JR  = 6'b001000;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b011;
  localparam logic [2:0] ALU_NOR = 3'b100;
  localparam logic [2:0] ALU_SRL = 3'b101;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_RT    = 2'd0;
  localparam logic [1:0] SRCB_4     = 2'd1;
  localparam logic [1:0] SRCB_IMM   = 2'd2;
  localparam logic [1:0] SRCB_IMMSH = 2'd3;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;
  localparam logic [1:0] PCSRC_RS     = 2'd3;

  localparam logic [1:0] DST_RT = 2'd0;
  localparam logic [1:0] DST_RD = 2'd1;
  localparam logic [1:0] DST_RA = 2'd2;

  localparam logic [1:0] WB_ALUOUT = 2'd0;
  localparam logic [1:0] WB_MDR    = 2'd1;
  localparam logic [1:0] WB_LUI    = 2'd2;
  localparam logic [1:0] WB_PC     = 2'd3;

endpackage

// File: rtl/mctrl_if.sv
// Control-to-datapath/memory bundle: status flows into the controller,
// selects, enables and memory strobes flow out.
interface mctrl_if;
  logic [31:0] Inst;
  logic        zero;
  logic        overflow;
  logic        MIO_ready;
  logic        MemRead;
  logic        MemWrite;
  logic        IorD;
  logic        IRWrite;
  logic [1:0]  RegDst;
  logic        RegWrite;
  logic [1:0]  MemtoReg;
  logic        ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [1:0]  PCSource;
  logic        PCWrite;
  logic        PCWriteCond;
  logic        Branch;
  logic [2:0]  ALU_operation;
  logic        shift;
  logic        unsign;
  logic [3:0]  state_out;

  modport master (
    input  Inst, zero, overflow, MIO_ready,
    output MemRead, MemWrite, IorD, IRWrite, RegDst, RegWrite, MemtoReg,
           ALUSrcA, ALUSrcB, PCSource, PCWrite, PCWriteCond, Branch,
           ALU_operation, shift, unsign, state_out
  );

  modport slave (
    output Inst, zero, overflow, MIO_ready,
    input  MemRead, MemWrite, IorD, IRWrite, RegDst, RegWrite, MemtoReg,
           ALUSrcA, ALUSrcB, PCSource, PCWrite, PCWriteCond, Branch,
           ALU_operation, shift, unsign, state_out
  );
endinterface

// File: rtl/mctrl_decode.sv
// Combinational instruction classifier: opcode/funct to class, ALU op and
// the per-instruction flags the FSM needs for both next-state and outputs.
module mctrl_decode
  import mctrl_pkg::*;
(
  input  logic [5:0] i_op,
  input  logic [5:0] i_funct,
  output inst_cls_t  o_cls,
  output logic [2:0] o_alu_op,
  output logic       o_unsign,
  output logic       o_shift,
  output logic       o_funct_ok,
  output logic       o_is_lw,
  output logic       o_is_beq,
  output logic       o_ov_en
);

  always_comb begin
    o_cls      = CL_BAD;
    o_alu_op   = ALU_AND;
    o_unsign   = 1'b0;
    o_shift    = 1'b0;
    o_funct_ok = 1'b0;
    o_is_lw    = 1'b0;
    o_is_beq   = 1'b0;
    o_ov_en    = 1'b0;
    case (i_op)
      OP_RTYPE: begin
        o_cls = (i_funct == FN_JR) ? CL_JR : CL_R;
        o_funct_ok = 1'b1;
        case (i_funct)
          FN_ADD:  begin o_alu_op = ALU_ADD; o_ov_en = 1'b1; end
          FN_SUB:  begin o_alu_op = ALU_SUB; o_ov_en = 1'b1; end
          FN_AND:  o_alu_op = ALU_AND;
          FN_OR:   o_alu_op = ALU_OR;
          FN_XOR:  o_alu_op = ALU_XOR;
          FN_NOR:  o_alu_op = ALU_NOR;
          FN_SLT:  o_alu_op = ALU_SLT;
          FN_SRL:  begin o_alu_op = ALU_SRL; o_shift = 1'b1; end
          default: o_funct_ok = 1'b0;
        endcase
      end
      OP_LW:   begin o_cls = CL_MEM; o_is_lw = 1'b1; end
      OP_SW:   o_cls = CL_MEM;
      OP_BEQ:  begin o_cls = CL_BR; o_is_beq = 1'b1; end
      OP_BNE:  o_cls = CL_BR;
      OP_J:    o_cls = CL_J;
      OP_JAL:  o_cls = CL_JAL;
      OP_ADDI: begin o_cls = CL_IMM; o_alu_op = ALU_ADD; o_ov_en = 1'b1; end
      OP_SLTI: begin o_cls = CL_IMM; o_alu_op = ALU_SLT; end
      OP_ANDI: begin o_cls = CL_IMM; o_alu_op = ALU_AND; o_unsign = 1'b1; end
      OP_ORI:  begin o_cls = CL_IMM; o_alu_op = ALU_OR;  o_unsign = 1'b1; end
      OP_XORI: begin o_cls = CL_IMM; o_alu_op = ALU_XOR; o_unsign = 1'b1; end
      OP_LUI:  o_cls = CL_LUI;
      default: o_cls = CL_BAD;
    endcase
  end

endmodule

// File: rtl/mctrl_fsm.sv
// Multicycle MIPS control unit: 16-state Moore FSM whose outputs are decoded
// from the current state and the latched instruction word.
module mctrl_fsm
  import mctrl_pkg::*;
#(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input logic   clk,
  input logic   reset,
  mctrl_if.master bus
);

  state_t     r_state;
  logic       r_ov_q;

  inst_cls_t  w_cls;
  logic [2:0] w_alu_op;
  logic       w_unsign;
  logic       w_shift;
  logic       w_funct_ok;
  logic       w_is_lw;
  logic       w_is_beq;
  logic       w_ov_en;

  mctrl_decode u_decode (
    .i_op       (bus.Inst[31:26]),
    .i_funct    (bus.Inst[5:0]),
    .o_cls      (w_cls),
    .o_alu_op   (w_alu_op),
    .o_unsign   (w_unsign),
    .o_shift    (w_shift),
    .o_funct_ok (w_funct_ok),
    .o_is_lw    (w_is_lw),
    .o_is_beq   (w_is_beq),
    .o_ov_en    (w_ov_en)
  );

  // ov_q carries the EXE-stage overflow into WB and is cleared on every return to IF.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= state_t'(RESET_STATE);
      r_ov_q  <= 1'b0;
    end else begin
      case (r_state)
        S_IF: begin
          r_ov_q <= 1'b0;
          if (bus.MIO_ready) r_state <= S_ID;
        end
        S_ID: begin
          case (w_cls)
            CL_MEM:  r_state <= S_MA;
            CL_R:    r_state <= S_RE;
            CL_JR:   r_state <= S_JR;
            CL_BR:   r_state <= S_BR;
            CL_J:    r_state <= S_J;
            CL_JAL:  r_state <= S_JAL;
            CL_IMM:  r_state <= S_IE;
            CL_LUI:  r_state <= S_LUI;
            default: r_state <= S_ERR;
          endcase
        end
        S_MA: r_state <= w_is_lw ? S_MR : S_MW;
        S_MR: if (bus.MIO_ready) r_state <= S_LW;
        S_MW: begin
          if (bus.MIO_ready) begin
            r_state <= S_IF;
            r_ov_q  <= 1'b0;
          end
        end
        S_RE: begin
          r_state <= w_funct_ok ? S_RW : S_ERR;
          r_ov_q  <= w_funct_ok & w_ov_en & bus.overflow;
        end
        S_IE: begin
          r_state <= S_IW;
          r_ov_q  <= w_ov_en & bus.overflow;
        end
        S_ERR: r_state <= S_ERR;
        default: begin
          r_state <= S_IF;
          r_ov_q  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    bus.MemRead       = 1'b0;
    bus.MemWrite      = 1'b0;
    bus.IorD          = 1'b0;
    bus.IRWrite       = 1'b0;
    bus.RegDst        = DST_RT;
    bus.RegWrite      = 1'b0;
    bus.MemtoReg      = WB_ALUOUT;
    bus.ALUSrcA       = 1'b0;
    bus.ALUSrcB       = SRCB_RT;
    bus.PCSource      = PCSRC_ALU;
    bus.PCWrite       = 1'b0;
    bus.PCWriteCond   = 1'b0;
    bus.Branch        = 1'b0;
    bus.ALU_operation = ALU_AND;
    bus.shift         = 1'b0;
    bus.unsign        = 1'b0;
    bus.state_out     = 4'd0;
    // Holding reset low silences every output, including pending memory strobes.
    if (reset) begin
      bus.state_out = r_state;
      case (r_state)
        S_IF: begin
          bus.MemRead       = 1'b1;
          bus.ALUSrcB       = SRCB_4;
          bus.ALU_operation = ALU_ADD;
          bus.PCWrite       = 1'b1;
          bus.IRWrite       = bus.MIO_ready;
        end
        S_ID: begin
          bus.ALUSrcB       = SRCB_IMMSH;
          bus.ALU_operation = ALU_ADD;
        end
        S_MA: begin
          bus.ALUSrcA       = 1'b1;
          bus.ALUSrcB       = SRCB_IMM;
          bus.ALU_operation = ALU_ADD;
        end
        S_MR: begin
          bus.MemRead = 1'b1;
          bus.IorD    = 1'b1;
        end
        S_LW: begin
          bus.MemtoReg = WB_MDR;
          bus.RegWrite = 1'b1;
        end
        S_MW: begin
          bus.MemWrite = 1'b1;
          bus.IorD     = 1'b1;
        end
        S_RE: begin
          bus.ALUSrcA       = 1'b1;
          bus.ALU_operation = w_alu_op;
          bus.shift         = w_shift;
        end
        S_RW: begin
          bus.RegDst   = DST_RD;
          bus.RegWrite = ~r_ov_q;
        end
        S_BR: begin
          bus.ALUSrcA       = 1'b1;
          bus.ALU_operation = ALU_SUB;
          bus.PCWriteCond   = 1'b1;
          bus.PCSource      = PCSRC_ALUOUT;
          bus.Branch        = w_is_beq;
        end
        S_J: begin
          bus.PCSource = PCSRC_JUMP;
          bus.PCWrite  = 1'b1;
        end
        S_IE: begin
          bus.ALUSrcA       = 1'b1;
          bus.ALUSrcB       = SRCB_IMM;
          bus.ALU_operation = w_alu_op;
          bus.unsign        = w_unsign;
        end
        S_IW: bus.RegWrite = ~r_ov_q;
        S_LUI: begin
          bus.MemtoReg = WB_LUI;
          bus.RegWrite = 1'b1;
        end
        S_JAL: begin
          bus.RegDst   = DST_RA;
          bus.MemtoReg = WB_PC;
          bus.RegWrite = 1'b1;
          bus.PCSource = PCSRC_JUMP;
          bus.PCWrite  = 1'b1;
        end
        S_JR: begin
          bus.PCSource = PCSRC_RS;
          bus.PCWrite  = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
